// File: rtl/ysyx_24110006_ifu.sv
// ysyx_24110006_ifu: single-outstanding instruction fetch unit with flush/redirect,
// stale-response dropping and misaligned-target exception packets.
module ysyx_24110006_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_resp_err,
    input  logic        i_flush,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_imm,
    output logic [31:0] o_pc,
    output logic        o_exception,
    output logic [3:0]  o_mcause
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t      state, state_n;
    logic [31:0] pc, pc_n, inst_n, pc_o_n, exc_pc;
    logic        drop, drop_n, valid_n, exc_n, req_fire, exc_now;
    logic [3:0]  cause_n;
    logic [4:0]  op;
    logic        i_type, s_type, b_type, u_type, j_type;
    assign o_mem_req_valid = !i_reset && state == REQ && !drop && pc[1:0] == 2'b00;
    assign o_mem_addr      = {pc[31:2], 2'b00};
    assign req_fire        = o_mem_req_valid && i_mem_req_ready;
    // A misaligned target (fresh redirect, or pc+4 after such a packet) never reaches the bus
    assign exc_pc          = i_flush ? i_redirect_pc : pc;
    assign exc_now         = (i_flush || state == REQ) && exc_pc[1:0] != 2'b00;
    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = o_valid;
        inst_n  = o_inst;
        pc_o_n  = o_pc;
        exc_n   = o_exception;
        cause_n = o_mcause;
        drop_n  = (i_flush && ((state == WAIT && !i_mem_resp_valid) || req_fire)) ? 1'b1 :
                  i_mem_resp_valid ? 1'b0 : drop;
        if (exc_now) begin
            inst_n  = 32'h0000_0013;
            pc_o_n  = exc_pc;
            exc_n   = 1'b1;
            cause_n = 4'd0;
            pc_n    = exc_pc + 32'd4;
            valid_n = 1'b1;
            state_n = HOLD;
        end else if (i_flush) begin
            valid_n = 1'b0;
            pc_n    = i_redirect_pc;
            state_n = REQ;
        end else begin
            case (state)
                REQ:  state_n = req_fire ? WAIT : REQ;
                WAIT: if (i_mem_resp_valid) begin
                    inst_n  = i_mem_rdata;
                    pc_o_n  = pc;
                    exc_n   = i_mem_resp_err;
                    cause_n = i_mem_resp_err ? 4'd1 : 4'd0;
                    pc_n    = pc + 32'd4;
                    valid_n = 1'b1;
                    state_n = HOLD;
                end
                HOLD: if (i_ready) begin
                    valid_n = 1'b0;
                    state_n = REQ;
                end
                default: state_n = REQ;
            endcase
        end
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            o_valid     <= 1'b0;
            o_inst      <= '0;
            o_pc        <= '0;
            o_exception <= 1'b0;
            o_mcause    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            drop        <= drop_n;
            o_valid     <= valid_n;
            o_inst      <= inst_n;
            o_pc        <= pc_o_n;
            o_exception <= exc_n;
            o_mcause    <= cause_n;
        end
    end
    assign op     = o_inst[6:2];
    assign i_type = op == 5'b00000 || op == 5'b00100 || op == 5'b11001 || op == 5'b11100;
    assign s_type = op == 5'b01000;
    assign b_type = op == 5'b11000;
    assign u_type = op == 5'b01101 || op == 5'b00101;
    assign j_type = op == 5'b11011;
    assign o_imm  = i_type ? {{20{o_inst[31]}}, o_inst[31:20]} :
                    s_type ? {{20{o_inst[31]}}, o_inst[31:25], o_inst[11:7]} :
                    b_type ? {{19{o_inst[31]}}, o_inst[31], o_inst[7], o_inst[30:25], o_inst[11:8], 1'b0} :
                    u_type ? {o_inst[31:12], 12'b0} :
                    j_type ? {{11{o_inst[31]}}, o_inst[31], o_inst[19:12], o_inst[20], o_inst[30:21], 1'b0} :
                    32'd0;
endmodule

// File: doc/ysyx_24110006_ifu.md
YSYX_24110006_IFU -- requirements
Module: ysyx_24110006_ifu

Interface
REQ-001 SHALL provide parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL provide ports (name direction width meaning):
- i_clock in 1 clock
- i_reset in 1 reset; synchronous, active-high
- o_mem_req_valid out 1 fetch request valid
- i_mem_req_ready in 1 memory accepts request
- o_mem_addr out 32 fetch address, word aligned
- i_mem_resp_valid in 1 response valid, one cycle pulse
- i_mem_rdata in 32 instruction word
- i_mem_resp_err in 1 bus error with response
- i_flush in 1 redirect request
- i_redirect_pc in 32 redirect target, sampled with i_flush
- o_valid out 1 decode packet valid
- i_ready in 1 decode stage accepts packet
- o_inst out 32 fetched instruction
- o_imm out 32 sign-extended immediate
- o_pc out 32 instruction address
- o_exception out 1 fetch exception flag
- o_mcause out 4 exception cause

Function
REQ-003 SHALL implement FSM IDLE, REQ, WAIT, HOLD; reset state REQ.
REQ-004 REQ: o_mem_req_valid=1, o_mem_addr=pc; handshake (valid & i_mem_req_ready) -> WAIT.
REQ-005 WAIT: on i_mem_resp_valid, capture o_inst=i_mem_rdata, o_pc=pc, o_exception=i_mem_resp_err, o_mcause=4'd1 if err else 4'd0; o_valid=1 next cycle; pc<=pc+4 (wraps mod 2^32); -> HOLD.
REQ-006 HOLD: o_valid=1; packet fields stable until o_valid & i_ready; on transfer -> REQ, o_valid<=0.
REQ-007 At most one memory request outstanding; no request issued while o_valid=1 and not transferring.
REQ-008 Minimum latency: request accept cycle N, response cycle N+1, o_valid cycle N+2.
REQ-009 o_imm SHALL be combinational from o_inst[6:2]: 00000/00100/11001/11100 I-type; 01000 S-type; 11000 B-type; 01101/00101 U-type; 11011 J-type; otherwise 0; all sign-extended from inst[31].
REQ-010 i_flush has priority over every other event in the same cycle: o_valid<=0, pc<=i_redirect_pc, state<=REQ.
REQ-011 Flush in WAIT (or in REQ with request accepted same cycle) SHALL set drop flag; next response discarded, not forwarded; state waits for it before issuing at redirect pc.
REQ-012 Flush coincident with response: response discarded, drop flag not set.
REQ-013 Redirect pc with [1:0]!=0: no bus request; packet o_inst=32'h0000_0013, o_pc=redirect pc, o_exception=1, o_mcause=4'd0, presented next cycle via HOLD.
REQ-014 o_mem_addr SHALL never carry a misaligned address.
REQ-015 After exception packet transfers, fetch continues at pc+4 unless flushed.

Reset
REQ-016 On i_reset: pc=RESET_PC, state=REQ, drop=0, o_valid=0, o_exception=0, o_mcause=0, o_inst=0, o_pc=0; o_mem_req_valid=0 during reset cycle.
REQ-017 Reset mid-transaction abandons outstanding response; first response after reset while drop=0 and state=REQ SHALL be ignored.

Verification
REQ-018 Reset, ready memory, rdata 32'h0010_0093 -> addr 0x8000_0000, o_valid at N+2, o_imm=1, o_pc=0x8000_0000; next addr 0x8000_0004.
REQ-019 i_ready=0 for 5 cycles in HOLD -> o_valid held, o_inst/o_pc unchanged, o_mem_req_valid=0.
REQ-020 Flush to 0x8000_0100 during WAIT, then response 0xDEAD_BEEF -> response dropped, next request addr 0x8000_0100, no packet with 0xDEAD_BEEF.
REQ-021 Response with i_mem_resp_err=1 at pc 0x8000_0008 -> o_exception=1, o_mcause=1, o_pc=0x8000_0008.
REQ-022 Flush to 0x8000_0102 -> no bus request, o_valid next cycle, o_exception=1, o_mcause=0, o_inst=0x0000_0013.
REQ-023 rdata 32'hFE00_0EE3 (BEQ, offset -4) -> o_imm=32'hFFFF_FFFC; JAL 32'h0080_006F -> o_imm=8.
